// File: rtl/pipe_mem_defs.sv
// Shared definitions for the IF/DM memory arbiter: state and grant encodings,
// default widths, the nop word and the grant-selection helper.
package pipe_mem_defs;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned WAIT_W = 8;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  // Tie-break: fixed DM priority, or alternate away from the last winner when rr_en.
  function automatic gnt_e arb_pick(input logic if_req, input logic dm_req,
                                    input gnt_e last_gnt, input logic rr_en);
    gnt_e pick;
    pick = GNT_IF;
    if (if_req && dm_req) begin
      if (rr_en) pick = (last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
      else       pick = GNT_DM;
    end else if (dm_req) begin
      pick = GNT_DM;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for a pending memory access: synchronous clear, count enable,
// terminal-count flag when the count reaches MAX_WAIT.
module mem_wait_timer
  import pipe_mem_defs::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WAIT_W-1:0] count;

  assign tc = (count == WAIT_W'(MAX_WAIT));

  // Holds at terminal count so a stalled caller never wraps.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the IF and DM ports onto one single-ported memory with a
// request/ready handshake. Define ARB_RR_EN for round-robin tie-breaking.
module pipe_mem_arbiter
  import pipe_mem_defs::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          if_stall,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout
);

  arb_state_e state, state_nxt;
  gnt_e       gnt_c;
  logic       busy_c;
  logic       start_c;
  logic       done_c;
  logic       wait_tc;

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  assign busy_c  = (state == BUSY_IF) || (state == BUSY_DM);
  assign start_c = (state == IDLE) && (if_req || dm_req);
  assign done_c  = busy_c && (mem_rdy || wait_tc);

`ifdef ARB_RR_EN
  gnt_e last_gnt;

  assign gnt_c = arb_pick(if_req, dm_req, last_gnt, 1'b1);

  // Remembers the most recent winner so the other port takes the next tie.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_gnt <= GNT_IF;
    end else if (start_c) begin
      last_gnt <= gnt_c;
    end
  end
`else
  assign gnt_c = arb_pick(if_req, dm_req, GNT_IF, 1'b0);
`endif

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clock  (clock),
    .resetn (resetn),
    .clr    (!busy_c),
    .en     (busy_c && !mem_rdy),
    .tc     (wait_tc)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_c) state_nxt = (gnt_c == GNT_DM) ? BUSY_DM : BUSY_IF;
      end
      BUSY_IF, BUSY_DM: begin
        if (done_c) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command, response capture, ack pulses and sticky timeout flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      timeout   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (start_c) begin
        mem_req <= 1'b1;
        if (gnt_c == GNT_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (done_c) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (!mem_rdy) timeout <= 1'b1;
        if (state == BUSY_DM) begin
          dm_ack   <= 1'b1;
          dm_rdata <= mem_rdy ? mem_rdata : DW'(NOP_WORD);
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdy ? mem_rdata : DW'(NOP_WORD);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares; a behavioural memory adds latency.
module tb_pipe_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NEVER = 1000;
  localparam int ACK_BOUND = 200;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          if_stall;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdy = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_dm;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_if = 32'h0;
  logic [31:0] mem [0:255];
  int          lat = 0;
  int          wcnt = 0;

  pipe_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(15)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdy   (mem_rdy),
    .mem_rdata (mem_rdata),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_dm, input bit chk_data, input logic [31:0] data);
    exp_t e;
    e.is_dm = is_dm;
    e.chk_data = chk_data;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Memory model: mem_rdy after `lat` request cycles, reads/writes the word array.
  always @(negedge clock) begin
    if (mem_req) begin
      if (wcnt == lat) begin
        mem_rdy = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_rdy = 1'b0;
        mem_rdata = 32'hBAD0_0000;
        wcnt++;
      end
    end else begin
      mem_rdy = 1'b0;
      wcnt = 0;
    end
  end

  task automatic check_ack(input bit is_dm, input logic [31:0] rdata);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: port %s got ack with empty scoreboard at %0t",
               is_dm ? "DM" : "IF", $time);
    end else begin
      e = sb_q.pop_front();
      check("ack_port", 32'(is_dm), 32'(e.is_dm));
      if (e.chk_data) check(is_dm ? "dm_rdata" : "if_rdata", rdata, e.data);
      if (is_dm) check("if_rdata_held", if_rdata, last_if);
      else last_if = e.data;
    end
  endtask

  // Monitor: compare every ack against the head of the scoreboard.
  always @(negedge clock) begin
    if (resetn) begin
      if (if_ack && dm_ack) check("dual_ack", 32'(1), 32'(0));
      if (if_ack) check_ack(1'b0, if_rdata);
      if (dm_ack) check_ack(1'b1, dm_rdata);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 is the first cycle after the request is driven.
  task automatic wait_ack(input bit is_dm, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < ACK_BOUND) begin
      @(negedge clock);
      if (is_dm ? dm_ack : if_ack) seen = 1'b1;
      else cyc++;
    end
    if (!seen) check(is_dm ? "dm_ack_bound" : "if_ack_bound", 32'(0), 32'(1));
  endtask

  initial begin
    int cyc;
    int first_cyc;
    int second_cyc;
    bit if_done;
    bit dm_done;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h2008_0005;   // 0x40
    mem[8'h11] = 32'hFFFF_FFFF;   // 0x44
    mem[8'h20] = 32'h0000_1234;   // 0x80

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_if_ack", 32'(if_ack), 32'(0));
    check("rst_dm_ack", 32'(dm_ack), 32'(0));
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_timeout", 32'(timeout), 32'(0));
    #1 resetn = 1'b1;

    // 1: minimum-latency fetch
    lat = 0;
    tick();
    if_req = 1'b1;
    if_addr = 32'h40;
    push(1'b0, 1'b1, 32'h2008_0005);
    @(negedge clock);
    check("t1_c0_stall", 32'(if_stall), 32'(1));
    check("t1_c0_ack", 32'(if_ack), 32'(0));
    @(negedge clock);
    check("t1_c1_mem_req", 32'(mem_req), 32'(1));
    check("t1_c1_mem_addr", mem_addr, 32'h40);
    check("t1_c1_mem_we", 32'(mem_we), 32'(0));
    check("t1_c1_stall", 32'(if_stall), 32'(1));
    @(negedge clock);
    check("t1_c2_ack", 32'(if_ack), 32'(1));
    check("t1_c2_stall", 32'(if_stall), 32'(0));
    tick();
    if_req = 1'b0;

    // 2: store, then load it back
    lat = 1;
    tick();
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    push(1'b1, 1'b0, 32'h0);
    @(negedge clock);
    @(negedge clock);
    check("t2_mem_req", 32'(mem_req), 32'(1));
    check("t2_mem_we", 32'(mem_we), 32'(1));
    check("t2_mem_addr", mem_addr, 32'h100);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_ack(1'b1, cyc);
    tick();
    dm_req = 1'b0;
    dm_we = 1'b0;
    @(negedge clock);
    check("t2_ack_pulse", 32'(dm_ack), 32'(0));
    tick();
    dm_req = 1'b1;
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    wait_ack(1'b1, cyc);
    check("t2_load_cycle", 32'(cyc), 32'(3));
    tick();
    dm_req = 1'b0;

    // 3: simultaneous requests, memory 3 cycles late
    lat = 3;
    tick();
    if_req = 1'b1;
    if_addr = 32'h40;
    dm_req = 1'b1;
    dm_addr = 32'h100;
`ifdef ARB_RR_EN
    push(1'b0, 1'b1, 32'h2008_0005);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
`else
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    push(1'b0, 1'b1, 32'h2008_0005);
`endif
    if_done = 1'b0;
    dm_done = 1'b0;
    cyc = 0;
    first_cyc = -1;
    second_cyc = -1;
    while (!(if_done && dm_done) && cyc < ACK_BOUND) begin
      @(negedge clock);
      if (if_ack || dm_ack) begin
        if (first_cyc < 0) first_cyc = cyc;
        else second_cyc = cyc;
      end
      if (if_ack) if_done = 1'b1;
      if (dm_ack) dm_done = 1'b1;
      @(posedge clock);
      #1;
      if (if_done) if_req = 1'b0;
      if (dm_done) dm_req = 1'b0;
      cyc++;
    end
    check("t3_both_done", 32'(if_done && dm_done), 32'(1));
    check("t3_first_cycle", 32'(first_cyc), 32'(5));
    check("t3_second_cycle", 32'(second_cyc), 32'(11));
    if_req = 1'b0;
    dm_req = 1'b0;

    // 5: ready arrives in the same cycle as the terminal count
    lat = 15;
    tick();
    if_req = 1'b1;
    if_addr = 32'h80;
    push(1'b0, 1'b1, 32'h0000_1234);
    wait_ack(1'b0, cyc);
    check("t5_ack_cycle", 32'(cyc), 32'(17));
    check("t5_timeout", 32'(timeout), 32'(0));
    tick();
    if_req = 1'b0;

    // 4: memory never ready -> abort with nop, sticky timeout
    lat = NEVER;
    tick();
    if_req = 1'b1;
    if_addr = 32'h44;
    push(1'b0, 1'b1, 32'h0);
    wait_ack(1'b0, cyc);
    check("t4_ack_cycle", 32'(cyc), 32'(17));
    check("t4_timeout", 32'(timeout), 32'(1));
    tick();
    if_req = 1'b0;
    repeat (100) @(negedge clock);
    check("t4_timeout_sticky", 32'(timeout), 32'(1));

    // 6: reset during BUSY_DM, request re-granted afterwards
    tick();
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h100;
    repeat (3) @(negedge clock);
    check("t6_busy_mem_req", 32'(mem_req), 32'(1));
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_mem_req", 32'(mem_req), 32'(0));
    check("t6_rst_dm_ack", 32'(dm_ack), 32'(0));
    check("t6_rst_timeout", 32'(timeout), 32'(0));
    @(negedge clock);
    check("t6_rst_dm_ack2", 32'(dm_ack), 32'(0));
    lat = 0;
    #1 resetn = 1'b1;
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    wait_ack(1'b1, cyc);
    tick();
    dm_req = 1'b0;

    repeat (5) @(negedge clock);
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
